// File: rtl/io_bus_hub.sv
// IO bus hub: decodes the IO window, runs a registered request/ack handshake to N slaves,
// and passes non-IO accesses through to data memory. Optional macro: IO_ERR_ADDR_EN (err_addr port).
module io_bus_hub #(
   parameter int          NUM_SLAVES     = 8,
   parameter int          SLOT_W         = 4,
   parameter int          SLOT_SHIFT     = 4,
   parameter logic [31:0] IO_BASE        = 32'hFFFFFC00,
   parameter int          TIMEOUT_CYCLES = 16
) (
   input  logic                     clk,
   input  logic                     isReset_n,
   input  logic                     isR,
   input  logic                     isW,
   input  logic [31:0]              addr,
   input  logic [31:0]              dW,
   input  logic [31:0]              dR_mem,
   output logic [31:0]              dR,
   output logic                     ready,
   output logic [NUM_SLAVES-1:0]    s_sel,
   output logic                     s_rd,
   output logic                     s_wr,
   output logic [SLOT_SHIFT-1:0]    s_addr,
   output logic [15:0]              s_wdata,
   input  logic [NUM_SLAVES*16-1:0] s_rdata,
   input  logic [NUM_SLAVES-1:0]    s_ack,
   output logic                     bus_err,
   output logic [7:0]               err_cnt,
   input  logic                     err_clr
`ifdef IO_ERR_ADDR_EN
   ,
   output logic [31:0]              err_addr
`endif
);

   localparam int HI_LSB = SLOT_SHIFT + SLOT_W;
   localparam int CNT_W  = $clog2(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

   state_t                  state_q, state_d;
   logic [SLOT_W-1:0]       slot_q, slot_d;
   logic                    wr_q, wr_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [31:0]             rdata_q, rdata_d;
   logic [NUM_SLAVES-1:0]   s_sel_q, s_sel_d;
   logic                    s_rd_q, s_rd_d, s_wr_q, s_wr_d;
   logic [SLOT_SHIFT-1:0]   s_addr_q, s_addr_d;
   logic [15:0]             s_wdata_q, s_wdata_d;
   logic                    bus_err_q, bus_err_d;
   logic [7:0]              err_cnt_q, err_cnt_d;
`ifdef IO_ERR_ADDR_EN
   logic [31:0]             addr_q, addr_d, err_addr_q, err_addr_d;
   logic [31:0]             err_src;
`endif

   logic                    req, io_hit, mapped, log_err;
   logic [SLOT_W-1:0]       slot;
   logic [NUM_SLAVES-1:0]   slot_onehot;
   logic                    sel_ack;
   logic [15:0]             sel_rdata;

   assign req    = isR | isW;
   assign io_hit = req && (addr[31:HI_LSB] == IO_BASE[31:HI_LSB]);
   assign slot   = addr[SLOT_SHIFT +: SLOT_W];
   assign mapped = int'(slot) < NUM_SLAVES;

   // Only the latched slot's ack/data are observed; every other slave is ignored.
   always_comb begin
      slot_onehot = '0;
      sel_ack     = 1'b0;
      sel_rdata   = 16'h0;
      for (int k = 0; k < NUM_SLAVES; k++) begin
         slot_onehot[k] = (slot == SLOT_W'(k));
         if (slot_q == SLOT_W'(k)) begin
            sel_ack   = s_ack[k];
            sel_rdata = s_rdata[16*k +: 16];
         end
      end
   end

   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
      state_d   = state_q;
      slot_d    = slot_q;
      wr_d      = wr_q;
      cnt_d     = cnt_q;
      rdata_d   = rdata_q;
      s_sel_d   = s_sel_q;
      s_rd_d    = 1'b0;
      s_wr_d    = 1'b0;
      s_addr_d  = s_addr_q;
      s_wdata_d = s_wdata_q;
      bus_err_d = bus_err_q;
      err_cnt_d = err_cnt_q;
      log_err   = 1'b0;
      dR        = dR_mem;
      ready     = 1'b0;
`ifdef IO_ERR_ADDR_EN
      addr_d     = addr_q;
      err_addr_d = err_addr_q;
      err_src    = addr_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (req && !io_hit) begin
               ready = 1'b1;
            end else if (io_hit) begin
`ifdef IO_ERR_ADDR_EN
               addr_d  = addr;
               err_src = addr;
`endif
               if (mapped) begin
                  slot_d    = slot;
                  wr_d      = isW;
                  s_addr_d  = addr[SLOT_SHIFT-1:0];
                  s_wdata_d = dW[15:0];
                  s_sel_d   = slot_onehot;
                  s_rd_d    = !isW;
                  s_wr_d    = isW;
                  cnt_d     = '0;
                  state_d   = REQ;
               end else begin
                  rdata_d = 32'h0;
                  log_err = 1'b1;
                  state_d = DONE;
               end
            end
         end
         REQ, WAIT: begin
            if (sel_ack) begin
               if (!wr_q) rdata_d = {16'h0, sel_rdata};
               s_sel_d = '0;
               state_d = DONE;
            end else if (state_q == WAIT && cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               rdata_d = 32'h0;
               log_err = 1'b1;
               s_sel_d = '0;
               state_d = DONE;
            end else begin
               cnt_d   = cnt_q + CNT_W'(1);
               state_d = WAIT;
            end
         end
         DONE: begin
            ready   = 1'b1;
            dR      = rdata_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // A logged error overrides a simultaneous clear.
      if (log_err) begin
         bus_err_d = 1'b1;
         err_cnt_d = err_clr ? 8'd1 : ((err_cnt_q == 8'hFF) ? 8'hFF : err_cnt_q + 8'd1);
`ifdef IO_ERR_ADDR_EN
         err_addr_d = err_src;
`endif
      end else if (err_clr) begin
         bus_err_d = 1'b0;
         err_cnt_d = 8'd0;
`ifdef IO_ERR_ADDR_EN
         err_addr_d = 32'h0;
`endif
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops update from the same pre-edge values.
   always_ff @(posedge clk or negedge isReset_n) begin
      if (!isReset_n) begin
         state_q   <= IDLE;
         slot_q    <= '0;
         wr_q      <= 1'b0;
         cnt_q     <= '0;
         rdata_q   <= 32'h0;
         s_sel_q   <= '0;
         s_rd_q    <= 1'b0;
         s_wr_q    <= 1'b0;
         s_addr_q  <= '0;
         s_wdata_q <= 16'h0;
         bus_err_q <= 1'b0;
         err_cnt_q <= 8'd0;
`ifdef IO_ERR_ADDR_EN
         addr_q     <= 32'h0;
         err_addr_q <= 32'h0;
`endif
      end else begin
         state_q   <= state_d;
         slot_q    <= slot_d;
         wr_q      <= wr_d;
         cnt_q     <= cnt_d;
         rdata_q   <= rdata_d;
         s_sel_q   <= s_sel_d;
         s_rd_q    <= s_rd_d;
         s_wr_q    <= s_wr_d;
         s_addr_q  <= s_addr_d;
         s_wdata_q <= s_wdata_d;
         bus_err_q <= bus_err_d;
         err_cnt_q <= err_cnt_d;
`ifdef IO_ERR_ADDR_EN
         addr_q     <= addr_d;
         err_addr_q <= err_addr_d;
`endif
      end
   end

   assign s_sel   = s_sel_q;
   assign s_rd    = s_rd_q;
   assign s_wr    = s_wr_q;
   assign s_addr  = s_addr_q;
   assign s_wdata = s_wdata_q;
   assign bus_err = bus_err_q;
   assign err_cnt = err_cnt_q;
`ifdef IO_ERR_ADDR_EN
   assign err_addr = err_addr_q;
`endif

endmodule

// File: tb/tb_io_bus_hub.sv
// Testbench for io_bus_hub: directed accesses, a transaction-level expectation model and
// a per-cycle compare process, plus literal pins on the headline scenarios.
module tb_io_bus_hub;

   localparam int NS = 8;
   localparam int T  = 16;

   logic          clk = 1'b0;
   logic          isReset_n = 1'b0;
   logic          isR = 1'b0, isW = 1'b0;
   logic [31:0]   addr = 32'h0, dW = 32'h0, dR_mem = 32'h0;
   logic [31:0]   dR;
   logic          ready;
   logic [NS-1:0] s_sel;
   logic          s_rd, s_wr;
   logic [3:0]    s_addr;
   logic [15:0]   s_wdata;
   logic [NS*16-1:0] s_rdata = '0;
   logic [NS-1:0] s_ack = '0;
   logic          bus_err;
   logic [7:0]    err_cnt;
   logic          err_clr = 1'b0;
`ifdef IO_ERR_ADDR_EN
   logic [31:0]   err_addr;
`endif

   io_bus_hub #(
      .NUM_SLAVES(NS), .SLOT_W(4), .SLOT_SHIFT(4), .IO_BASE(32'hFFFFFC00), .TIMEOUT_CYCLES(T)
   ) dut (
      .clk(clk), .isReset_n(isReset_n), .isR(isR), .isW(isW), .addr(addr), .dW(dW),
      .dR_mem(dR_mem), .dR(dR), .ready(ready), .s_sel(s_sel), .s_rd(s_rd), .s_wr(s_wr),
      .s_addr(s_addr), .s_wdata(s_wdata), .s_rdata(s_rdata), .s_ack(s_ack),
      .bus_err(bus_err), .err_cnt(err_cnt), .err_clr(err_clr)
`ifdef IO_ERR_ADDR_EN
      , .err_addr(err_addr)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Expected outputs for the current cycle, produced from the access description.
   logic          chk_en = 1'b0, chk_dr = 1'b0;
   logic          exp_ready = 1'b0, exp_rd = 1'b0, exp_wr = 1'b0, exp_bus_err = 1'b0;
   logic [NS-1:0] exp_sel = '0;
   logic [3:0]    exp_s_addr = '0;
   logic [15:0]   exp_s_wdata = '0;
   logic [7:0]    exp_err_cnt = '0;
   logic [31:0]   exp_dR = '0, exp_err_addr = '0;
   logic          clr_pending = 1'b0;
   logic [31:0]   mem_val = 32'h5A5A0000;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
   endtask

   always @(negedge clk) begin
      #2;
      if (chk_en) begin
         check("ready",   32'(ready),   32'(exp_ready));
         check("s_sel",   32'(s_sel),   32'(exp_sel));
         check("s_rd",    32'(s_rd),    32'(exp_rd));
         check("s_wr",    32'(s_wr),    32'(exp_wr));
         check("s_addr",  32'(s_addr),  32'(exp_s_addr));
         check("s_wdata", 32'(s_wdata), 32'(exp_s_wdata));
         check("bus_err", 32'(bus_err), 32'(exp_bus_err));
         check("err_cnt", 32'(err_cnt), 32'(exp_err_cnt));
         if (chk_dr) check("dR", dR, exp_dR);
`ifdef IO_ERR_ADDR_EN
         check("err_addr", err_addr, exp_err_addr);
`endif
      end
   end

   task automatic apply_pending();
      if (clr_pending) begin
         exp_bus_err  = 1'b0;
         exp_err_cnt  = 8'd0;
         exp_err_addr = 32'h0;
         clr_pending  = 1'b0;
      end
   endtask

   task automatic idle(input logic clr);
      @(negedge clk);
      apply_pending();
      isR = 1'b0; isW = 1'b0; err_clr = clr; s_ack = '0;
      dR_mem = mem_val ^ 32'h00FF00FF;
      exp_ready = 1'b0; exp_sel = '0; exp_rd = 1'b0; exp_wr = 1'b0;
      chk_dr = 1'b1; exp_dR = dR_mem; chk_en = 1'b1;
      clr_pending = clr;
   endtask

   // ack_at: select-cycle index of the ack (0 = REQ cycle), negative = slave never acks.
   task automatic access(input logic wr, input logic both, input logic [31:0] a,
                         input logic [31:0] wd, input int ack_at, input logic [15:0] rdat,
                         input logic clr_entry, output int sel_cycles, output int ready_cycle,
                         output logic [31:0] dr_rdy, output logic [NS-1:0] sel_c2);
      int slot, n_sel, total;
      logic io, mapped, err;
      slot   = int'(a[7:4]);
      io     = (a[31:8] == 24'hFFFFFC);
      mapped = io && (slot < NS);
      n_sel  = (ack_at >= 0) ? ack_at + 1 : T;
      total  = !io ? 1 : (!mapped ? 2 : n_sel + 2);
      err    = io && (!mapped || ack_at < 0);
      sel_cycles = 0; ready_cycle = 0; dr_rdy = 32'h0; sel_c2 = '0;
      for (int c = 1; c <= total; c++) begin
         @(negedge clk);
         apply_pending();
         isR = !wr || both; isW = wr; addr = a; dW = wd;
         dR_mem  = mem_val + 32'(c - 1);
         err_clr = clr_entry && (c == total - 1);
         for (int k = 0; k < NS; k++)
            s_rdata[16*k +: 16] = (k == slot) ? rdat : 16'h1000 + 16'(k);
         s_ack = '0;
         s_ack[(slot + 1) % NS] = 1'b1;
         if (mapped && ack_at >= 0 && c == ack_at + 2) s_ack[slot] = 1'b1;

         exp_ready = (c == total);
         exp_sel   = (mapped && c >= 2 && c <= n_sel + 1) ? NS'(1 << slot) : '0;
         exp_rd    = mapped && c == 2 && !wr;
         exp_wr    = mapped && c == 2 && wr;
         if (mapped && c == 2) begin
            exp_s_addr  = a[3:0];
            exp_s_wdata = wd[15:0];
         end
         chk_dr = 1'b1;
         exp_dR = dR_mem;
         if (c == total && io) begin
            if (wr) chk_dr = 1'b0;
            else exp_dR = err ? 32'h0 : {16'h0, rdat};
            if (err) begin
               exp_bus_err  = 1'b1;
               exp_err_cnt  = clr_entry ? 8'd1 : ((exp_err_cnt == 8'hFF) ? 8'hFF : exp_err_cnt + 8'd1);
               exp_err_addr = a;
            end
         end
         chk_en = 1'b1;
         #1;
         if (s_sel != '0) sel_cycles++;
         if (c == 2) sel_c2 = s_sel;
         if (ready) begin
            ready_cycle = c;
            dr_rdy      = dR;
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int sc, rc;
      logic [31:0] dv;
      logic [NS-1:0] s2;

      repeat (2) @(negedge clk);
      check("rst_s_sel",   32'(s_sel),   32'h0);
      check("rst_bus_err", 32'(bus_err), 32'h0);
      check("rst_err_cnt", 32'(err_cnt), 32'h0);
      check("rst_s_addr",  32'(s_addr),  32'h0);
      isReset_n = 1'b1;
      idle(1'b0); idle(1'b0);

      // Write to slave 6, ack in REQ.
      access(1'b1, 1'b0, 32'hFFFFFC60, 32'h1234A5A5, 0, 16'h0, 1'b0, sc, rc, dv, s2);
      check("wr_sel_c2", 32'(s2), 32'h40);
      check("wr_ready_cycle", 32'(rc), 32'd3);
      check("wr_sel_cycles", 32'(sc), 32'd1);
      check("wr_bus_err", 32'(bus_err), 32'h0);
      idle(1'b0);

      // Read slave 7, ack after 3 WAIT cycles.
      access(1'b0, 1'b0, 32'hFFFFFC74, 32'h0, 3, 16'hBEEF, 1'b0, sc, rc, dv, s2);
      check("rd_ready_cycle", 32'(rc), 32'd6);
      check("rd_dR", dv, 32'h0000BEEF);
      check("rd_s_addr", 32'(s_addr), 32'h4);
      idle(1'b0);

      // Read slave 4, never acks: timeout.
      access(1'b0, 1'b0, 32'hFFFFFC40, 32'h0, -1, 16'h7777, 1'b0, sc, rc, dv, s2);
      check("to_sel_cycles", 32'(sc), 32'd16);
      check("to_ready_cycle", 32'(rc), 32'd18);
      check("to_dR", dv, 32'h0);
      check("to_err_cnt", 32'(err_cnt), 32'd1);
`ifdef IO_ERR_ADDR_EN
      check("to_err_addr", err_addr, 32'hFFFFFC40);
`endif
      idle(1'b0);

      // Unmapped slot 9.
      access(1'b0, 1'b0, 32'hFFFFFC90, 32'h0, 0, 16'h0, 1'b0, sc, rc, dv, s2);
      check("um_ready_cycle", 32'(rc), 32'd2);
      check("um_sel_cycles", 32'(sc), 32'd0);
      check("um_err_cnt", 32'(err_cnt), 32'd2);
      idle(1'b1); idle(1'b0);
      check("clr_err_cnt", 32'(err_cnt), 32'd0);

      // Non-IO read and write pass straight through.
      mem_val = 32'hCAFEF00D;
      access(1'b0, 1'b0, 32'h00001000, 32'h0, 0, 16'h0, 1'b0, sc, rc, dv, s2);
      check("mem_ready_cycle", 32'(rc), 32'd1);
      check("mem_dR", dv, 32'hCAFEF00D);
      access(1'b1, 1'b0, 32'h00002004, 32'h11112222, 0, 16'h0, 1'b0, sc, rc, dv, s2);
      idle(1'b0);

      // isR and isW together act as a write; ack in the last allowed WAIT cycle still wins.
      access(1'b1, 1'b1, 32'hFFFFFC1C, 32'h0000C3C3, 1, 16'h0, 1'b0, sc, rc, dv, s2);
      access(1'b0, 1'b0, 32'hFFFFFC28, 32'h0, T - 1, 16'h4321, 1'b0, sc, rc, dv, s2);
      check("late_ack_dR", dv, 32'h00004321);
      check("late_ack_bus_err", 32'(bus_err), 32'h0);
      idle(1'b0);

      // Error logged in the same cycle as a clear: error wins.
      access(1'b1, 1'b0, 32'hFFFFFCA0, 32'h0, 0, 16'h0, 1'b0, sc, rc, dv, s2);
      access(1'b0, 1'b0, 32'hFFFFFCF4, 32'h0, 0, 16'h0, 1'b1, sc, rc, dv, s2);
      check("win_err_cnt", 32'(err_cnt), 32'd1);
      access(1'b0, 1'b0, 32'hFFFFFC50, 32'h0, -1, 16'h0, 1'b1, sc, rc, dv, s2);
      idle(1'b0);

      // Saturation of the error counter.
      mem_val = 32'h13572468;
      for (int i = 0; i < 260; i++)
         access(1'b0, 1'b0, 32'hFFFFFC80 + 32'(16 * (i % 8)), 32'h0, 0, 16'h0, 1'b0, sc, rc, dv, s2);
      check("sat_err_cnt", 32'(err_cnt), 32'd255);
      idle(1'b1); idle(1'b0);

      // Reset asserted while in WAIT.
      chk_en = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         isR = 1'b1; isW = 1'b0; addr = 32'hFFFFFC40; s_ack = '0; err_clr = 1'b0;
      end
      #1;
      check("pre_rst_sel", 32'(s_sel), 32'h10);
      @(negedge clk);
      isReset_n = 1'b0;
      #1;
      check("rst_mid_sel", 32'(s_sel), 32'h0);
      check("rst_mid_ready", 32'(ready), 32'h0);
      check("rst_mid_s_addr", 32'(s_addr), 32'h0);
      exp_s_addr = '0; exp_s_wdata = '0; exp_bus_err = 1'b0; exp_err_cnt = '0; exp_err_addr = '0;
      @(negedge clk);
      isR = 1'b0;
      isReset_n = 1'b1;
      idle(1'b0);
      access(1'b1, 1'b0, 32'hFFFFFC08, 32'h0000ABCD, 1, 16'h0, 1'b0, sc, rc, dv, s2);
      check("reissue_ready_cycle", 32'(rc), 32'd4);
      check("reissue_sel_c2", 32'(s2), 32'h01);
      idle(1'b0); idle(1'b0);
      chk_en = 1'b0;
      @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
